// File: rtl/verilog_lexer.sv
// Streaming lexer: splits an ASCII byte stream into WORD/NUMBER/PUNCT/DIRECTIVE/EOS/ERROR
// tokens, one input byte per cycle inside a token, with a ready/valid handshake on both sides.
module verilog_lexer #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LINE_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   tok_valid,
  input  logic                   tok_ready,
  output logic [2:0]             tok_class,
  output logic [4:0]             tok_len,
  output logic [8*MAX_LEN-1:0]   tok_text,
  output logic [LINE_W-1:0]      tok_line,
  output logic                   tok_trunc
);

  localparam int unsigned LEN_W  = 5;
  localparam int unsigned TEXT_W = 8 * MAX_LEN;

  localparam logic [2:0] CLS_WORD   = 3'd0;
  localparam logic [2:0] CLS_NUMBER = 3'd1;
  localparam logic [2:0] CLS_PUNCT  = 3'd2;
  localparam logic [2:0] CLS_DIR    = 3'd3;
  localparam logic [2:0] CLS_EOS    = 3'd4;
  localparam logic [2:0] CLS_ERROR  = 3'd5;

  localparam logic [2:0] CH_LETTER = 3'd0;
  localparam logic [2:0] CH_DIGIT  = 3'd1;
  localparam logic [2:0] CH_DOLLAR = 3'd2;
  localparam logic [2:0] CH_HASH   = 3'd3;
  localparam logic [2:0] CH_SPACE  = 3'd4;
  localparam logic [2:0] CH_NL     = 3'd5;
  localparam logic [2:0] CH_PUNCT  = 3'd6;
  localparam logic [2:0] CH_ERR    = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT, S_EMIT_PEND} state_e;

  // '$' gets its own class: it continues a token but opens a PUNCT token on its own.
  function automatic logic [2:0] char_class(input logic [7:0] b);
    logic [2:0] c;
    if ((b >= 8'h61 && b <= 8'h7a) || (b >= 8'h41 && b <= 8'h5a) || b == 8'h5f) c = CH_LETTER;
    else if (b >= 8'h30 && b <= 8'h39)                  c = CH_DIGIT;
    else if (b == 8'h24)                                c = CH_DOLLAR;
    else if (b == 8'h23)                                c = CH_HASH;
    else if (b == 8'h20 || b == 8'h09 || b == 8'h0d)    c = CH_SPACE;
    else if (b == 8'h0a)                                c = CH_NL;
    else if (b >= 8'h21 && b <= 8'h7e)                  c = CH_PUNCT;
    else                                                c = CH_ERR;
    return c;
  endfunction

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  tok_valid_q, tok_valid_d;
  logic [2:0]            tok_class_q, tok_class_d;
  logic [LEN_W-1:0]      tok_len_q, tok_len_d;
  logic [TEXT_W-1:0]     tok_text_q, tok_text_d;
  logic [LINE_W-1:0]     tok_line_q, tok_line_d;
  logic                  tok_trunc_q, tok_trunc_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [7:0]            pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  eos_q, eos_d;
  logic                  load_eos;

  logic       acc, tok_xfer, proc_en, proc_last, in_cont, pend_tok;
  logic [7:0] proc_byte;
  logic [2:0] proc_cls, in_cls, pend_cls;

  // IDLE and EMIT_PEND share the token-start rules; EMIT_PEND feeds the held byte instead.
  assign acc       = in_valid && in_ready_q;
  assign tok_xfer  = tok_valid_q && tok_ready;
  assign proc_en   = (state_q == S_EMIT_PEND) || (state_q == S_IDLE && acc);
  assign proc_byte = (state_q == S_EMIT_PEND) ? pend_q : in_data;
  assign proc_last = (state_q == S_EMIT_PEND) ? eos_q : in_last;
  assign proc_cls  = char_class(proc_byte);
  assign in_cls    = char_class(in_data);
  assign in_cont   = (in_cls == CH_LETTER) || (in_cls == CH_DIGIT) || (in_cls == CH_DOLLAR);
  assign pend_cls  = char_class(pend_q);
  assign pend_tok  = pend_vld_q && (pend_cls != CH_SPACE) && (pend_cls != CH_NL);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_EMIT_PEND: begin
        if (proc_en) begin
          case (proc_cls)
            CH_LETTER, CH_DIGIT, CH_HASH: state_d = proc_last ? S_EMIT : S_ACCUM;
            CH_SPACE, CH_NL:              state_d = proc_last ? S_EMIT : S_IDLE;
            default:                      state_d = S_EMIT;
          endcase
        end
      end
      S_ACCUM: begin
        if (acc) state_d = (in_cont && !in_last) ? S_ACCUM : S_EMIT;
      end
      S_EMIT: begin
        if (tok_xfer) begin
          if (pend_tok)   state_d = S_EMIT_PEND;
          else if (eos_q) state_d = S_EMIT;
          else            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tok_valid_d = tok_valid_q;
    tok_class_d = tok_class_q;
    tok_len_d   = tok_len_q;
    tok_text_d  = tok_text_q;
    tok_line_d  = tok_line_q;
    tok_trunc_d = tok_trunc_q;
    line_d      = line_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    eos_d       = eos_q;
    load_eos    = 1'b0;
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_ACCUM);

    case (state_q)
      S_IDLE, S_EMIT_PEND: begin
        if (proc_en) begin
          if (state_q == S_EMIT_PEND) pend_vld_d = 1'b0;
          if (proc_cls == CH_SPACE || proc_cls == CH_NL) begin
            if (proc_cls == CH_NL) line_d = line_q + LINE_W'(1);
            if (proc_last) load_eos = 1'b1;
          end else begin
            case (proc_cls)
              CH_LETTER: tok_class_d = CLS_WORD;
              CH_DIGIT:  tok_class_d = CLS_NUMBER;
              CH_HASH:   tok_class_d = CLS_DIR;
              CH_ERR:    tok_class_d = CLS_ERROR;
              default:   tok_class_d = CLS_PUNCT;
            endcase
            tok_len_d        = LEN_W'(1);
            tok_text_d       = '0;
            tok_text_d[7:0]  = proc_byte;
            tok_line_d       = line_q;
            tok_trunc_d      = 1'b0;
            tok_valid_d      = proc_last || (proc_cls == CH_PUNCT) ||
                               (proc_cls == CH_DOLLAR) || (proc_cls == CH_ERR);
            eos_d            = proc_last;
          end
        end
      end
      S_ACCUM: begin
        if (acc) begin
          if (in_cont) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
              if (tok_len_q == LEN_W'(k)) tok_text_d[8*k +: 8] = in_data;
            end
            if (tok_len_q == LEN_W'(MAX_LEN)) tok_trunc_d = 1'b1;
            else                              tok_len_d   = tok_len_q + LEN_W'(1);
            if (in_last) begin
              tok_valid_d = 1'b1;
              eos_d       = 1'b1;
            end
          end else begin
            tok_valid_d = 1'b1;
            pend_d      = in_data;
            pend_vld_d  = 1'b1;
            eos_d       = in_last;
          end
        end
      end
      S_EMIT: begin
        if (tok_xfer) begin
          tok_valid_d = 1'b0;
          if (!pend_tok) begin
            pend_vld_d = 1'b0;
            if (pend_vld_q && pend_cls == CH_NL) line_d = line_q + LINE_W'(1);
            if (eos_q)                          load_eos = 1'b1;
            else if (tok_class_q == CLS_EOS)    line_d = LINE_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (load_eos) begin
      tok_valid_d = 1'b1;
      tok_class_d = CLS_EOS;
      tok_len_d   = '0;
      tok_text_d  = '0;
      tok_trunc_d = 1'b0;
      tok_line_d  = line_d;
      eos_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_class_q <= '0;
      tok_len_q   <= '0;
      tok_text_q  <= '0;
      tok_line_q  <= '0;
      tok_trunc_q <= 1'b0;
      line_q      <= LINE_W'(1);
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      eos_q       <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      tok_valid_q <= tok_valid_d;
      tok_class_q <= tok_class_d;
      tok_len_q   <= tok_len_d;
      tok_text_q  <= tok_text_d;
      tok_line_q  <= tok_line_d;
      tok_trunc_q <= tok_trunc_d;
      line_q      <= line_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      eos_q       <= eos_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign tok_valid = tok_valid_q;
  assign tok_class = tok_class_q;
  assign tok_len   = tok_len_q;
  assign tok_text  = tok_text_q;
  assign tok_line  = tok_line_q;
  assign tok_trunc = tok_trunc_q;

endmodule
